ax_level_governor: RTL and testbench

Parametrised successor to the core's single global approximation-level select, which takes a fixed default or an external level when enabled. This block holds an independent approximation level per consumer channel (e.g. ch0 = branch decider, ch1 = D-cache). It accepts level-change requests through a valid/ready handshake and applies each change only at a pipeline-quiescent safe point. Level changes ramp one step at a time with a dwell interval between steps, unless the request is forced. Sits beside CSR_Unit; its axLevel vector feeds the approximate units.

---
 rtl/ax_level_governor.sv | 165 ++++++++++++++++
 tb/tb_ax_level_governor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ax_level_governor.sv
// Per-channel approximation-level governor: ramps each channel's level toward a requested target at pipeline-quiescent safe points.
// Optional statistics counters are enabled with `define RSD_AX_LEVEL_STAT_EN.
module ax_level_governor #(
  parameter int NUM_CH          = 2,
  parameter int LEVEL_WIDTH     = 3,
  parameter int MAX_LEVEL       = 7,
  parameter int DEFAULT_LEVEL   = 0,
  parameter int DWELL_CYCLES    = 16,
  parameter int QUIESCE_TIMEOUT = 1024,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          reqValid,
  output logic                          reqReady,
  input  logic [CH_W-1:0]               reqCh,
  input  logic [LEVEL_WIDTH-1:0]        reqLevel,
  input  logic                          reqForce,
  input  logic                          quiescent,
  output logic                          stallReq,
  output logic [NUM_CH*LEVEL_WIDTH-1:0] axLevel,
  output logic                          busy,
  output logic                          changeDone,
  output logic                          timeoutErr,
  output logic [31:0]                   statStallCycles,
  output logic [NUM_CH*16-1:0]          statSteps
);

  localparam int TO_W = $clog2(QUIESCE_TIMEOUT + 1);
  localparam int DW_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [LEVEL_WIDTH-1:0] MAX_L = LEVEL_WIDTH'(MAX_LEVEL);
  localparam logic [LEVEL_WIDTH-1:0] DEF_L = LEVEL_WIDTH'(DEFAULT_LEVEL);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(QUIESCE_TIMEOUT - 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, STEP, HOLD} state_t;

  state_t                          state_q, state_d;
  logic [CH_W-1:0]                 tgt_ch;
  logic [LEVEL_WIDTH-1:0]          tgt_lvl;
  logic                            force_q;
  logic [NUM_CH*LEVEL_WIDTH-1:0]   level_q;
  logic [TO_W-1:0]                 to_cnt;
  logic [DW_W-1:0]                 dw_cnt;
  logic                            done_q, err_q;

  logic                            accept, ch_ok, done_d, err_d;
  logic [LEVEL_WIDTH-1:0]          clamp_lvl, cur_req, cur_tgt, next_lvl;

  // Handshake: a request transfers on any cycle where reqValid && reqReady; reqReady is high only in IDLE.
  assign accept    = reqValid && (state_q == IDLE);
  assign clamp_lvl = (reqLevel > MAX_L) ? MAX_L : reqLevel;

  always_comb begin
    cur_req = '0;
    cur_tgt = '0;
    ch_ok   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == reqCh) begin
        cur_req = level_q[i*LEVEL_WIDTH +: LEVEL_WIDTH];
        ch_ok   = 1'b1;
      end
      if (CH_W'(i) == tgt_ch) cur_tgt = level_q[i*LEVEL_WIDTH +: LEVEL_WIDTH];
    end
  end

  always_comb begin
    next_lvl = cur_tgt;
    if (force_q)                next_lvl = tgt_lvl;
    else if (cur_tgt < tgt_lvl) next_lvl = cur_tgt + LEVEL_WIDTH'(1);
    else if (cur_tgt > tgt_lvl) next_lvl = cur_tgt - LEVEL_WIDTH'(1);
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!ch_ok)                    err_d   = 1'b1;
          else if (clamp_lvl == cur_req) done_d  = 1'b1;
          else                           state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Quiescence takes priority over a timeout landing in the same cycle.
        if (quiescent) state_d = STEP;
        else if (to_cnt == TO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      STEP: begin
        state_d = HOLD;
        if (next_lvl == tgt_lvl) done_d = 1'b1;
      end
      HOLD: begin
        if (dw_cnt == DW_LAST) state_d = (cur_tgt == tgt_lvl) ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tgt_ch  <= '0;
      tgt_lvl <= '0;
      force_q <= 1'b0;
      level_q <= {NUM_CH{DEF_L}};
      to_cnt  <= '0;
      dw_cnt  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (accept) begin
        tgt_ch  <= reqCh;
        tgt_lvl <= clamp_lvl;
        force_q <= reqForce;
      end
      to_cnt <= (state_q == DRAIN && state_d == DRAIN) ? to_cnt + TO_W'(1) : '0;
      dw_cnt <= (state_q == HOLD && state_d == HOLD) ? dw_cnt + DW_W'(1) : '0;
      if (state_q == STEP) begin
        for (int i = 0; i < NUM_CH; i++)
          if (CH_W'(i) == tgt_ch) level_q[i*LEVEL_WIDTH +: LEVEL_WIDTH] <= next_lvl;
      end
    end
  end

  assign reqReady   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign stallReq   = (state_q == DRAIN) || (state_q == STEP);
  assign axLevel    = level_q;
  assign changeDone = done_q;
  assign timeoutErr = err_q;

`ifdef RSD_AX_LEVEL_STAT_EN
  logic [31:0]          stall_cnt_q;
  logic [NUM_CH*16-1:0] steps_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      steps_q     <= '0;
    end else begin
      if (stallReq && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (state_q == STEP) begin
        for (int i = 0; i < NUM_CH; i++)
          if (CH_W'(i) == tgt_ch) steps_q[i*16 +: 16] <= steps_q[i*16 +: 16] + 16'd1;
      end
    end
  end

  assign statStallCycles = stall_cnt_q;
  assign statSteps       = steps_q;
`else
  assign statStallCycles = '0;
  assign statSteps       = '0;
`endif

endmodule

// File: tb/tb_ax_level_governor.sv
// Directed bench for ax_level_governor: three channels, 4-bit levels, short dwell/timeout, hand-computed cycle timings.
module tb_ax_level_governor;
  localparam int NCH = 3;
  localparam int LW  = 4;
  localparam int CHW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic               reqValid = 1'b0, reqForce = 1'b0, quiescent = 1'b1;
  logic [CHW-1:0]     reqCh = '0;
  logic [LW-1:0]      reqLevel = '0;
  logic               reqReady, stallReq, busy, changeDone, timeoutErr;
  logic [NCH*LW-1:0]  axLevel;
  logic [31:0]        statStallCycles;
  logic [NCH*16-1:0]  statSteps;

  logic               d_reqReady, d_stallReq, d_busy, d_changeDone, d_timeoutErr;
  logic [NCH*LW-1:0]  d_axLevel;
  logic [31:0]        d_statStallCycles;
  logic [NCH*16-1:0]  d_statSteps;

  ax_level_governor #(.NUM_CH(NCH), .LEVEL_WIDTH(LW), .MAX_LEVEL(7), .DEFAULT_LEVEL(0),
                      .DWELL_CYCLES(16), .QUIESCE_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady), .reqCh(reqCh),
    .reqLevel(reqLevel), .reqForce(reqForce), .quiescent(quiescent), .stallReq(stallReq),
    .axLevel(axLevel), .busy(busy), .changeDone(changeDone), .timeoutErr(timeoutErr),
    .statStallCycles(statStallCycles), .statSteps(statSteps)
  );

  ax_level_governor #(.NUM_CH(NCH), .LEVEL_WIDTH(LW), .MAX_LEVEL(7), .DEFAULT_LEVEL(3),
                      .DWELL_CYCLES(16), .QUIESCE_TIMEOUT(8)) dut_d (
    .clk(clk), .rst(rst), .reqValid(1'b0), .reqReady(d_reqReady), .reqCh(2'd0),
    .reqLevel(4'd0), .reqForce(1'b0), .quiescent(1'b1), .stallReq(d_stallReq),
    .axLevel(d_axLevel), .busy(d_busy), .changeDone(d_changeDone), .timeoutErr(d_timeoutErr),
    .statStallCycles(d_statStallCycles), .statSteps(d_statSteps)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] lv(input logic [NCH*LW-1:0] v, input int ch);
    return v[ch*LW +: LW];
  endfunction

  task automatic send(input int ch, input int lvl, input bit frc);
    reqCh    = CHW'(ch);
    reqLevel = LW'(lvl);
    reqForce = frc;
    reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    reqForce = 1'b0;
  endtask

  // Sample n = edges after the accept edge; records first-event indices and counts.
  int done_at, err_at, ready_at, busy_cnt, stall_cnt, done_cnt, err_cnt;
  logic [NCH*LW-1:0] hist [0:99];

  task automatic watch(input int ncyc, input int q_rise);
    done_at = -1; err_at = -1; ready_at = -1;
    busy_cnt = 0; stall_cnt = 0; done_cnt = 0; err_cnt = 0;
    for (int n = 0; n <= ncyc; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (n == q_rise) quiescent = 1'b1;
      hist[n] = axLevel;
      if (changeDone) begin done_cnt++; if (done_at < 0) done_at = n; end
      if (timeoutErr) begin err_cnt++;  if (err_at < 0)  err_at  = n; end
      if (reqReady && ready_at < 0) ready_at = n;
      if (busy)     busy_cnt++;
      if (stallReq) stall_cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_axlevel",  64'(axLevel), 64'h000);
    check_eq("rst_ready",    64'(reqReady), 64'd1);
    check_eq("rst_busy",     64'(busy), 64'd0);
    check_eq("rst_stall",    64'(stallReq), 64'd0);
    check_eq("rst_pulses",   64'({changeDone, timeoutErr}), 64'd0);
    check_eq("rst_stat",     64'(statStallCycles) | 64'(statSteps), 64'd0);
    check_eq("rst_default3", 64'(d_axLevel), 64'h333);
    check_eq("rst_default3_ready", 64'(d_reqReady), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Unforced ramp ch1 0 -> 3
    send(1, 3, 1'b0);
    watch(60, -1);
    check_eq("ramp_done_at",  64'(done_at), 64'd38);
    check_eq("ramp_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("ramp_ready_at", 64'(ready_at), 64'd54);
    check_eq("ramp_lvl_n2",   64'(lv(hist[2], 1)), 64'd1);
    check_eq("ramp_lvl_n19",  64'(lv(hist[19], 1)), 64'd1);
    check_eq("ramp_lvl_n20",  64'(lv(hist[20], 1)), 64'd2);
    check_eq("ramp_final",    64'(lv(axLevel, 1)), 64'd3);
    check_eq("ramp_ch0",      64'(lv(axLevel, 0)), 64'd0);
    check_eq("ramp_no_err",   64'(err_cnt), 64'd0);

    // Forced jump ch0 0 -> 5
    send(0, 5, 1'b1);
    watch(25, -1);
    check_eq("force_done_at",  64'(done_at), 64'd2);
    check_eq("force_busy",     64'(busy_cnt), 64'd18);
    check_eq("force_ready_at", 64'(ready_at), 64'd18);
    check_eq("force_lvl_n1",   64'(lv(hist[1], 0)), 64'd0);
    check_eq("force_final",    64'(lv(axLevel, 0)), 64'd5);

    // Drain timeout, quiescent held low
    quiescent = 1'b0;
    send(0, 2, 1'b0);
    watch(12, -1);
    check_eq("to_stall_cnt", 64'(stall_cnt), 64'd8);
    check_eq("to_err_at",    64'(err_at), 64'd8);
    check_eq("to_err_cnt",   64'(err_cnt), 64'd1);
    check_eq("to_no_done",   64'(done_cnt), 64'd0);
    check_eq("to_ready_at",  64'(ready_at), 64'd8);
    check_eq("to_level",     64'(lv(axLevel, 0)), 64'd5);

    // Quiescence arriving in the last drain cycle wins; ramp 5 -> 2
    quiescent = 1'b0;
    send(0, 2, 1'b0);
    watch(65, 7);
    check_eq("qlate_no_err",   64'(err_cnt), 64'd0);
    check_eq("qlate_lvl_n8",   64'(lv(hist[8], 0)), 64'd5);
    check_eq("qlate_lvl_n9",   64'(lv(hist[9], 0)), 64'd4);
    check_eq("qlate_done_at",  64'(done_at), 64'd45);
    check_eq("qlate_ready_at", 64'(ready_at), 64'd61);
    check_eq("qlate_final",    64'(lv(axLevel, 0)), 64'd2);

    // Clamp 9 -> 7 on ch2
    send(2, 9, 1'b1);
    watch(22, -1);
    check_eq("clamp_done_at", 64'(done_at), 64'd2);
    check_eq("clamp_level",   64'(lv(axLevel, 2)), 64'd7);

    // Request equal to current level
    send(2, 7, 1'b0);
    watch(3, -1);
    check_eq("eq_done_at",  64'(done_at), 64'd0);
    check_eq("eq_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("eq_stall",    64'(stall_cnt), 64'd0);
    check_eq("eq_busy",     64'(busy_cnt), 64'd0);

    // Nonexistent channel
    send(3, 1, 1'b1);
    watch(3, -1);
    check_eq("badch_err_at",  64'(err_at), 64'd0);
    check_eq("badch_err_cnt", 64'(err_cnt), 64'd1);
    check_eq("badch_no_done", 64'(done_cnt), 64'd0);
    check_eq("badch_busy",    64'(busy_cnt), 64'd0);
    check_eq("badch_levels",  64'(axLevel), 64'h732);

    // Reset during HOLD of a ramp ch0 2 -> 0
    send(0, 0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    check_eq("hold_busy",  64'(busy), 64'd1);
    check_eq("hold_level", 64'(lv(axLevel, 0)), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("mrst_axlevel", 64'(axLevel), 64'h000);
    check_eq("mrst_ready",   64'(reqReady), 64'd1);
    check_eq("mrst_busy",    64'(busy), 64'd0);
    check_eq("mrst_stall",   64'(stallReq), 64'd0);
    check_eq("mrst_pulses",  64'({changeDone, timeoutErr}), 64'd0);
    check_eq("mrst_stat",    64'(statStallCycles) | 64'(statSteps), 64'd0);
    check_eq("mrst_default3", 64'(d_axLevel), 64'h333);
    rst = 1'b1;

    send(1, 1, 1'b1);
    watch(25, -1);
    check_eq("post_done_at",  64'(done_at), 64'd2);
    check_eq("post_ready_at", 64'(ready_at), 64'd18);
    check_eq("post_levels",   64'(axLevel), 64'h010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
